// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory port arbiter.
package imem_pkg;

  localparam int unsigned IMEM_ADDR_W     = 8;
  localparam int unsigned IMEM_DATA_W     = 32;
  localparam int unsigned IMEM_HOST_BURST = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_HOST = 2'd1,
    OWN_CORE = 2'd2
  } owner_e;

endpackage : imem_pkg

// File: rtl/imem_port_arbiter.sv
// Shares one single-port instruction memory between a host loader and a core
// fetch port; per-cycle arbitration with bounded host bursts under contention.
module imem_port_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W     = IMEM_ADDR_W,
  parameter int unsigned DATA_W     = IMEM_DATA_W,
  parameter int unsigned HOST_BURST = IMEM_HOST_BURST
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_mode,

  input  logic [ADDR_W-1:0]     h_address,
  input  logic [DATA_W/8-1:0]   h_byteenable,
  input  logic                  h_read,
  input  logic                  h_write,
  input  logic [DATA_W-1:0]     h_writedata,
  output logic                  h_waitrequest,
  output logic [DATA_W-1:0]     h_readdata,
  output logic                  h_readdatavalid,

  input  logic [ADDR_W-1:0]     c_address,
  input  logic                  c_read,
  output logic                  c_waitrequest,
  output logic [DATA_W-1:0]     c_readdata,
  output logic                  c_readdatavalid,

  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(HOST_BURST);

  owner_e           owner;
  logic             host_req;
  logic             core_req;
  logic             contended;
  logic             grant_h;
  logic             grant_c;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             rd_h_q, rd_h_d;
  logic             rd_c_q, rd_c_d;

  // Grant selection, burst accounting and read-return tags.
  always_comb begin
    owner       = OWN_NONE;
    burst_cnt_d = '0;
    host_req    = h_read | h_write;
    core_req    = c_read & ~load_mode;
    contended   = host_req & core_req;

    if (!reset) begin
      if (host_req && (!core_req || (burst_cnt_q < BURST_MAX))) begin
        owner = OWN_HOST;
      end else if (core_req) begin
        owner = OWN_CORE;
      end
    end

    grant_h = (owner == OWN_HOST);
    grant_c = (owner == OWN_CORE);

    if (grant_h && contended) begin
      burst_cnt_d = (burst_cnt_q >= BURST_MAX) ? BURST_MAX : burst_cnt_q + CNT_W'(1);
    end

    // A simultaneous read+write from the host is a write and returns nothing.
    rd_h_d = grant_h & h_read & ~h_write;
    rd_c_d = grant_c;
  end

  // Memory slave drive: host fields are the idle default.
  always_comb begin
    mem_address    = h_address;
    mem_byteenable = h_byteenable;
    mem_writedata  = h_writedata;
    if (grant_c) begin
      mem_address    = c_address;
      mem_byteenable = {BE_W{1'b1}};
      mem_writedata  = '0;
    end
    mem_chipselect = grant_h | grant_c;
    mem_write      = grant_h & h_write;
    mem_clken      = 1'b1;
  end

  // Waitrequest and routed read return; reset suppresses an in-flight valid.
  always_comb begin
    h_waitrequest   = host_req & ~grant_h;
    c_waitrequest   = c_read & ~grant_c;
    h_readdatavalid = rd_h_q & ~reset;
    c_readdatavalid = rd_c_q & ~reset;
    h_readdata      = h_readdatavalid ? mem_readdata : '0;
    c_readdata      = c_readdatavalid ? mem_readdata : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_cnt_q <= '0;
      rd_h_q      <= 1'b0;
      rd_c_q      <= 1'b0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      rd_h_q      <= rd_h_d;
      rd_c_q      <= rd_c_d;
    end
  end

endmodule : imem_port_arbiter

// File: tb/tb_imem_port_arbiter.sv
// Directed self-checking bench for imem_port_arbiter with a behavioural 256x32 memory.
module tb_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_mode;
  logic [7:0]  h_address;
  logic [3:0]  h_byteenable;
  logic        h_read;
  logic        h_write;
  logic [31:0] h_writedata;
  logic        h_waitrequest;
  logic [31:0] h_readdata;
  logic        h_readdatavalid;
  logic [7:0]  c_address;
  logic        c_read;
  logic        c_waitrequest;
  logic [31:0] c_readdata;
  logic        c_readdatavalid;
  logic [7:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic        mem_clken;
  logic [31:0] mem_readdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_arr [256];
  logic [31:0] exp_mem [256];

  always #5 clk = ~clk;

  imem_port_arbiter dut (
    .clk(clk), .reset(reset), .load_mode(load_mode),
    .h_address(h_address), .h_byteenable(h_byteenable), .h_read(h_read),
    .h_write(h_write), .h_writedata(h_writedata), .h_waitrequest(h_waitrequest),
    .h_readdata(h_readdata), .h_readdatavalid(h_readdatavalid),
    .c_address(c_address), .c_read(c_read), .c_waitrequest(c_waitrequest),
    .c_readdata(c_readdata), .c_readdatavalid(c_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  // Single-port memory: one-cycle read latency, byte-lane writes.
  always_ff @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) mem_arr[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
      end
      mem_readdata <= mem_arr[mem_address];
    end
  end

  task automatic idle_inputs();
    h_read = 1'b0; h_write = 1'b0; c_read = 1'b0;
    h_address = 8'h00; h_byteenable = 4'h0; h_writedata = 32'h0;
    c_address = 8'h00;
  endtask

  // One host write cycle; also keeps the expected memory image.
  task automatic host_write_cycle(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    idle_inputs();
    h_write = 1'b1; h_address = a; h_writedata = d; h_byteenable = be;
    #1;
    checks++;
    if (h_waitrequest !== 1'b0 || mem_write !== 1'b1) begin
      errors++;
      $display("FAIL host_write a=%02h wait=%b mem_write=%b required wait=0 mem_write=1", a, h_waitrequest, mem_write);
    end
    for (int b = 0; b < 4; b++) if (be[b]) exp_mem[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; load_mode = 1'b0;
    idle_inputs();
    h_read = 1'b1; c_read = 1'b1;
    #1;
    checks++;
    if (mem_chipselect !== 1'b0 || h_waitrequest !== 1'b1 || c_waitrequest !== 1'b1 ||
        h_readdatavalid !== 1'b0 || c_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs cs=%b hw=%b cw=%b hv=%b cv=%b required 0 1 1 0 0",
               mem_chipselect, h_waitrequest, c_waitrequest, h_readdatavalid, c_readdatavalid);
    end
    checks++;
    if (mem_clken !== 1'b1) begin
      errors++;
      $display("FAIL clken got %b required 1", mem_clken);
    end
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    host_write_cycle(8'h10, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    idle_inputs();
    h_read = 1'b1; h_address = 8'h10;
    #1;
    checks++;
    if (h_waitrequest !== 1'b0 || h_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_issue wait=%b valid=%b required 0 0", h_waitrequest, h_readdatavalid);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (h_readdatavalid !== 1'b1 || h_readdata !== 32'hDEADBEEF || c_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_return hv=%b data=%08h cv=%b required 1 deadbeef 0",
               h_readdatavalid, h_readdata, c_readdatavalid);
    end
  endtask

  task automatic test_load_mode();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      idle_inputs();
      load_mode = 1'b1;
      c_read = 1'b1; c_address = 8'h00;
      if (i < 8) begin
        h_write = 1'b1; h_address = 8'(i); h_writedata = 32'hA000_0000 + 32'(i); h_byteenable = 4'hF;
        exp_mem[i] = 32'hA000_0000 + 32'(i);
      end
      #1;
      checks++;
      if (c_waitrequest !== 1'b1 || c_readdatavalid !== 1'b0 || (i < 8 && h_waitrequest !== 1'b0)) begin
        errors++;
        $display("FAIL load_mode_stall cyc=%0d cw=%b cv=%b hw=%b required 1 0 0", i, c_waitrequest, c_readdatavalid, h_waitrequest);
      end
    end
    @(negedge clk);
    idle_inputs();
    load_mode = 1'b0;
    c_read = 1'b1; c_address = 8'h00;
    #1;
    checks++;
    if (c_waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL load_mode_release cw=%b required 0", c_waitrequest);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (c_readdatavalid !== 1'b1 || c_readdata !== 32'hA000_0000 || h_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL load_mode_fetch cv=%b data=%08h hv=%b required 1 a0000000 0", c_readdatavalid, c_readdata, h_readdatavalid);
    end
  endtask

  task automatic test_contention();
    logic [7:0] ha;
    logic [7:0] ca;
    logic [1:0] prev;   // 0 none, 1 host, 2 core
    logic [7:0] prev_a;
    for (int i = 0; i < 16; i++) host_write_cycle(8'h20 + 8'(i), 32'hB000_0000 + 32'(i), 4'hF);
    ha = 8'h20; ca = 8'h00; prev = 2'd0; prev_a = 8'h00;
    for (int j = 0; j < 15; j++) begin
      logic exp_core;
      exp_core = ((j % 5) == 4);
      @(negedge clk);
      idle_inputs();
      h_read = 1'b1; h_address = ha;
      c_read = 1'b1; c_address = ca;
      #1;
      checks++;
      if (h_waitrequest !== exp_core || c_waitrequest !== !exp_core || mem_chipselect !== 1'b1) begin
        errors++;
        $display("FAIL contention_grant cyc=%0d hw=%b cw=%b cs=%b required hw=%b cw=%b cs=1",
                 j, h_waitrequest, c_waitrequest, mem_chipselect, exp_core, !exp_core);
      end
      checks++;
      if (h_readdatavalid !== (prev == 2'd1) || c_readdatavalid !== (prev == 2'd2) ||
          (prev == 2'd1 && h_readdata !== exp_mem[prev_a]) ||
          (prev == 2'd2 && c_readdata !== exp_mem[prev_a])) begin
        errors++;
        $display("FAIL contention_return cyc=%0d hv=%b hd=%08h cv=%b cd=%08h required owner=%0d data=%08h",
                 j, h_readdatavalid, h_readdata, c_readdatavalid, c_readdata, prev, exp_mem[prev_a]);
      end
      if (exp_core) begin prev = 2'd2; prev_a = ca; ca = ca + 8'd1; end
      else          begin prev = 2'd1; prev_a = ha; ha = ha + 8'd1; end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (c_readdatavalid !== 1'b1 || c_readdata !== exp_mem[prev_a] || h_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL contention_drain cv=%b cd=%08h hv=%b required 1 %08h 0", c_readdatavalid, c_readdata, h_readdatavalid, exp_mem[prev_a]);
    end
  endtask

  task automatic test_byte_enable();
    host_write_cycle(8'h05, 32'h12345678, 4'hF);
    host_write_cycle(8'h05, 32'h0000A5A5, 4'h3);
    @(negedge clk);
    idle_inputs();
    h_read = 1'b1; h_address = 8'h05;
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (h_readdatavalid !== 1'b1 || h_readdata !== 32'h1234A5A5) begin
      errors++;
      $display("FAIL byte_enable hv=%b data=%08h required 1 1234a5a5", h_readdatavalid, h_readdata);
    end
  endtask

  task automatic test_reset_inflight();
    // Four contended host grants bring the burst counter to its limit.
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      idle_inputs();
      h_read = 1'b1; h_address = 8'h20 + 8'(j);
      c_read = 1'b1; c_address = 8'h00;
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (h_readdatavalid !== 1'b0 || mem_chipselect !== 1'b0) begin
      errors++;
      $display("FAIL reset_suppress_host hv=%b cs=%b required 0 0", h_readdatavalid, mem_chipselect);
    end
    @(negedge clk);
    reset = 1'b0;
    h_address = 8'h21;
    #1;
    checks++;
    if (h_waitrequest !== 1'b0 || c_waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL reset_burst_clear hw=%b cw=%b required 0 1", h_waitrequest, c_waitrequest);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (h_readdatavalid !== 1'b1 || h_readdata !== exp_mem[8'h21]) begin
      errors++;
      $display("FAIL reset_first_read hv=%b hd=%08h required 1 %08h", h_readdatavalid, h_readdata, exp_mem[8'h21]);
    end
    // Core read accepted, then reset in the return cycle.
    @(negedge clk);
    idle_inputs();
    c_read = 1'b1; c_address = 8'h01;
    #1;
    checks++;
    if (c_waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL reset_core_accept cw=%b required 0", c_waitrequest);
    end
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
    checks++;
    if (c_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_suppress_core cv=%b required 0", c_readdatavalid);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (c_readdatavalid !== 1'b0 || h_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_after cv=%b hv=%b required 0 0", c_readdatavalid, h_readdatavalid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 8; i < 16; i++) host_write_cycle(8'(i), 32'hC000_0000 + 32'(i), 4'hF);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      idle_inputs();
      c_read = 1'b1; c_address = 8'(i);
      #1;
      checks++;
      if (c_waitrequest !== 1'b0 || mem_chipselect !== 1'b1 || mem_address !== 8'(i) || mem_byteenable !== 4'hF) begin
        errors++;
        $display("FAIL b2b_issue i=%0d cw=%b cs=%b addr=%02h be=%h required 0 1 %02h f",
                 i, c_waitrequest, mem_chipselect, mem_address, mem_byteenable, i);
      end
      if (i > 0) begin
        checks++;
        if (c_readdatavalid !== 1'b1 || c_readdata !== exp_mem[i-1] || h_readdatavalid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_return i=%0d cv=%b cd=%08h required 1 %08h", i - 1, c_readdatavalid, c_readdata, exp_mem[i-1]);
        end
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (c_readdatavalid !== 1'b1 || c_readdata !== exp_mem[15] || mem_chipselect !== 1'b0) begin
      errors++;
      $display("FAIL b2b_last cv=%b cd=%08h cs=%b required 1 %08h 0", c_readdatavalid, c_readdata, mem_chipselect, exp_mem[15]);
    end
    @(negedge clk);
    #1;
    checks++;
    if (c_readdatavalid !== 1'b0 || c_readdata !== 32'h0) begin
      errors++;
      $display("FAIL b2b_idle cv=%b cd=%08h required 0 00000000", c_readdatavalid, c_readdata);
    end
  endtask

  initial begin
    reset = 1'b1;
    load_mode = 1'b0;
    idle_inputs();
    for (int i = 0; i < 256; i++) exp_mem[i] = 32'h0;
    test_reset();
    test_write_read();
    test_load_mode();
    test_contention();
    test_byte_enable();
    test_reset_inflight();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_imem_port_arbiter

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares one single-port 256x32 instruction memory between two requesters: a host loader (read/write) and a processor core fetch port (read only).
- Arbitrates per cycle, drives the memory slave, and routes the one-cycle-latency read data back with a per-master readdatavalid.
- One instance sits in front of each core's instruction memory in the MPSoC.
- A load_mode input lets the host lock out the core while a program image is written.

Parameters:
- ADDR_W, 8, word address width (memory depth 2^ADDR_W).
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- HOST_BURST, 4, maximum consecutive contended host grants before the core is granted once (range 1..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- load_mode  in  1  1 = core fetch blocked, host owns memory.
- h_address  in  ADDR_W  host word address.
- h_byteenable  in  DATA_W/8  host write byte lanes.
- h_read  in  1  host read request.
- h_write  in  1  host write request.
- h_writedata  in  DATA_W  host write data.
- h_waitrequest  out  1  host request not accepted this cycle.
- h_readdata  out  DATA_W  host read data.
- h_readdatavalid  out  1  h_readdata valid.
- c_address  in  ADDR_W  core fetch address.
- c_read  in  1  core fetch request.
- c_waitrequest  out  1  core request not accepted this cycle.
- c_readdata  out  DATA_W  fetched instruction.
- c_readdatavalid  out  1  c_readdata valid.
- mem_address  out  ADDR_W  to memory address.
- mem_byteenable  out  DATA_W/8  to memory byteenable.
- mem_chipselect  out  1  to memory chipselect.
- mem_write  out  1  to memory write.
- mem_writedata  out  DATA_W  to memory writedata.
- mem_clken  out  1  memory clock enable, constant 1.
- mem_readdata  in  DATA_W  from memory; valid the cycle after the address is presented.

Behaviour:
- Request definitions:
  - host_req = h_read | h_write. If h_read and h_write are both high, the request is treated as a write.
  - core_req = c_read & ~load_mode.
- Grant (combinational from requests and registered state):
  - Only host requests: grant host.
  - Only core requests: grant core.
  - Both request: grant host while burst_cnt < HOST_BURST, otherwise grant core.
  - load_mode=1: core is never granted.
- Waitrequest:
  - h_waitrequest = host_req & ~grant_h.
  - c_waitrequest = c_read & ~grant_c. This includes load_mode=1, so the core stalls and does not error.
  - Acceptance = request high and waitrequest low in the same cycle.
- Memory drive:
  - mem_chipselect = grant_h | grant_c.
  - mem_write = grant_h & h_write.
  - Address, byteenable and writedata are muxed from the granted master.
  - Core byteenable is all ones; core writedata is 0.
  - With no grant, fields hold the host values and chipselect=0.
- burst_cnt (4 bits, registered):
  - Contended host grant: +1.
  - Core grant: cleared.
  - Uncontended host grant or idle: cleared.
  - load_mode=1: cleared.
  - Saturates at HOST_BURST.
- Read return (latency exactly 1 cycle):
  - Registered tags rd_h and rd_c are set on an accepted host read or core read respectively.
  - Next cycle: x_readdatavalid = rd_x, and x_readdata = mem_readdata, muxed so the non-owner sees 0.
  - Writes produce no response.
  - Back-to-back reads from either master give one valid per cycle.
- Read-after-write to the same address in consecutive cycles returns the new data, because the port is single and writes are issued in order.
- load_mode rising while a core read is in flight: that read's valid is still delivered next cycle.
- Reset: burst_cnt=0, rd_h=rd_c=0, so both readdatavalid=0.
  - Outputs during reset: mem_chipselect=0 and both waitrequest follow their request inputs (host and core both stalled).
  - A reset asserted in the cycle after an accepted read suppresses that readdatavalid.

Decomposition:
- Shared package imem_pkg:
  - IMEM_ADDR_W=8, IMEM_DATA_W=32.
  - Owner enum {OWN_NONE, OWN_HOST, OWN_CORE}.
  - Default HOST_BURST.
- No sub-module: the grant/burst logic and the return-tag pipeline fit in one module.
- The memory is instantiated beside the block, not inside it.

Test Plan:
- Host writes 0xDEADBEEF to addr 0x10 (be=0xF), then reads 0x10 the next cycle -> h_waitrequest=0 both cycles; h_readdatavalid one cycle after the read with h_readdata=0xDEADBEEF; c_readdatavalid=0.
- load_mode=1 with core c_read addr 0x00 held for 10 cycles while the host writes 8 words -> c_waitrequest=1 for all 10 cycles; after load_mode=0 the core is accepted the next cycle and gets the loaded word.
- Continuous contention with HOST_BURST=4, host reading 0x20.., core reading 0x00.. -> grant pattern H,H,H,H,C repeating; exactly one readdatavalid per cycle, routed to the correct owner with the matching data.
- Host write (be=0x3, data 0x0000A5A5) over a word preset to 0x12345678 at addr 0x05, then host read -> 0x1234A5A5.
- Core read accepted, reset asserted the next cycle -> c_readdatavalid=0; after reset, burst_cnt=0 and the first contended grant goes to the host.
- Core alone issues 16 back-to-back reads of 0x00..0x0F -> c_waitrequest=0 throughout; 16 consecutive valids in address order; mem_chipselect=1 for those 16 cycles.
